// File: rtl/pipe_stall_ctrl.sv
// Stall and replay controller for the five-stage pipeline. It merges the load-use
// and multi-cycle stall requests, drives the stage stall bus and replays the ID word.
module pipe_stall_ctrl #(
    parameter int STALL_W    = 6,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               md_done,
    input  logic [31:0]        inst_sram_rdata,
    input  logic               cnt_clr,
    output logic [STALL_W-1:0] stall,
    output logic [31:0]        inst_out,
    output logic               replay_valid,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               md_timeout
);

    localparam int MD_CNT_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

    // Stop PC/IF/ID/EX for a multi-cycle op; only PC/IF/ID for a load-use bubble.
    localparam logic [STALL_W-1:0] STALL_MD = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_LU = STALL_W'(6'b000111);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MD_WAIT  = 2'd2,
        REPLAY   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         hold_q, hold_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_timeout_q, md_timeout_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic [STALL_W-1:0]  stall_c;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        hold_d       = hold_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        stall_c      = '0;

        if (flush) begin
            state_d  = IDLE;
            md_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE, REPLAY: begin
                    // Re-entry from REPLAY keeps the word already held for ID.
                    if (stallreq_ex) begin
                        stall_c  = STALL_MD;
                        md_cnt_d = '0;
                        state_d  = MD_WAIT;
                        if (state_q == IDLE) hold_d = inst_sram_rdata;
                    end else if (stallreq_id) begin
                        stall_c = STALL_LU;
                        state_d = LU_STALL;
                        if (state_q == IDLE) hold_d = inst_sram_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LU_STALL: state_d = REPLAY;
                MD_WAIT: begin
                    stall_c  = STALL_MD;
                    md_cnt_d = md_cnt_q + MD_CNT_W'(1);
                    if (md_done) begin
                        state_d = REPLAY;
                    end else if (md_cnt_q == MD_LAST) begin
                        md_timeout_d = 1'b1;
                        state_d      = REPLAY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign stall        = rst ? '0 : stall_c;
    assign replay_valid = (state_q == REPLAY);
    assign inst_out     = replay_valid ? hold_q : inst_sram_rdata;
    assign stall_cycles = stall_cycles_q;
    assign md_timeout   = md_timeout_q;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (cnt_clr) begin
            stall_cycles_d = '0;
        end else if (stall[0] && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            md_cnt_q       <= '0;
            md_timeout_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            md_cnt_q       <= md_cnt_d;
            md_timeout_q   <= md_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: a mode-flag model checked every cycle, plus directed
// literal expectations. A CNT_W=4 copy shares the inputs to exercise saturation.
module tb_pipe_stall_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst, flush, sid, sex, done, clr;
    logic [31:0] rdata;

    logic [5:0]  stall,  stall4;
    logic [31:0] inst,   inst4;
    logic        rv,     rv4;
    logic [31:0] sc;
    logic [3:0]  sc4;
    logic        to,     to4;

    pipe_stall_ctrl #(.STALL_W(6), .MD_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stallreq_id(sid), .stallreq_ex(sex),
        .md_done(done), .inst_sram_rdata(rdata), .cnt_clr(clr), .stall(stall),
        .inst_out(inst), .replay_valid(rv), .stall_cycles(sc), .md_timeout(to)
    );

    pipe_stall_ctrl #(.STALL_W(6), .MD_TIMEOUT(TO), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .stallreq_id(sid), .stallreq_ex(sex),
        .md_done(done), .inst_sram_rdata(rdata), .cnt_clr(clr), .stall(stall4),
        .inst_out(inst4), .replay_valid(rv4), .stall_cycles(sc4), .md_timeout(to4)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit run     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode flags plus the number of cycles a multi-cycle op has been waited on.
    bit          m_md = 0, m_bubble = 0, m_replay = 0, m_flag = 0;
    int          m_age = 0;
    logic [31:0] m_held = '0;
    longint      m_cnt32 = 0;
    int          m_cnt4 = 0;
    logic [5:0]  m_s;

    function automatic logic [5:0] exp_stall();
        if (rst === 1'b1 || flush) return 6'b000000;
        if (m_md)     return 6'b001111;
        if (m_bubble) return 6'b000000;
        if (sex)      return 6'b001111;
        if (sid)      return 6'b000111;
        return 6'b000000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_md = 0; m_bubble = 0; m_replay = 0; m_flag = 0; m_age = 0;
            m_held = '0; m_cnt32 = 0; m_cnt4 = 0;
        end else begin
            m_s = exp_stall();
            if (clr) begin
                m_cnt32 = 0;
                m_cnt4  = 0;
            end else if (m_s[0]) begin
                if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush) begin
                m_md = 0; m_bubble = 0; m_replay = 0;
            end else if (m_md) begin
                m_age++;
                if (done) begin
                    m_md = 0; m_replay = 1;
                end else if (m_age == TO) begin
                    m_flag = 1; m_md = 0; m_replay = 1;
                end
            end else if (m_bubble) begin
                m_bubble = 0; m_replay = 1;
            end else begin
                if (!m_replay && (sex || sid)) m_held = rdata;
                m_replay = 0;
                if (sex) begin
                    m_md = 1; m_age = 0;
                end else if (sid) begin
                    m_bubble = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("stall",         stall,  exp_stall());
            check("stall_w4",      stall4, exp_stall());
            check("replay_valid",  rv,     m_replay);
            check("inst_out",      inst,   m_replay ? m_held : rdata);
            check("inst_out_w4",   inst4,  m_replay ? m_held : rdata);
            check("stall_cycles",  sc,     m_cnt32);
            check("stall_cyc_w4",  sc4,    m_cnt4);
            check("md_timeout",    to,     m_flag);
            check("md_timeout_w4", to4,    m_flag);
        end
    end

    task automatic cyc(input bit ex, input bit id, input bit dn, input bit fl,
                       input bit cl, input logic [31:0] rd);
        @(posedge clk);
        #1;
        sex = ex; sid = id; done = dn; flush = fl; clr = cl; rdata = rd;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 0; sid = 0; sex = 0; done = 0; clr = 0; rdata = '0;
        run = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_stall", stall, 6'b0);
        check("rst_rv", rv, 1'b0);
        check("rst_cnt", sc, 32'd0);
        check("rst_to", to, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Load-use: one stall cycle, one bubble, one replay.
        cyc(0, 1, 0, 0, 0, 32'h8C43_0004);
        check("lu_stall", stall, 6'b000111);
        cyc(0, 0, 0, 0, 0, 32'h1111_1111);
        check("lu_bubble", stall, 6'b000000);
        cyc(0, 0, 0, 0, 0, 32'h2222_2222);
        check("lu_replay_rv", rv, 1'b1);
        check("lu_replay_inst", inst, 32'h8C43_0004);
        cyc(0, 0, 0, 0, 0, 32'h3333_3333);
        check("lu_idle_inst", inst, 32'h3333_3333);
        check("lu_count", sc, 32'd1);

        // Divide: request cycle plus ten MD_WAIT cycles, md_done on the tenth.
        cyc(0, 0, 0, 0, 1, 32'h0);
        cyc(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        check("md_stall0", stall, 6'b001111);
        for (int i = 1; i < 10; i++) cyc(0, 0, 0, 0, 0, 32'h100 + i);
        cyc(0, 0, 1, 0, 0, 32'h0000_0AAA);
        check("md_done_stall", stall, 6'b001111);
        cyc(0, 0, 0, 0, 0, 32'h0000_0BBB);
        check("md_replay_inst", inst, 32'hDEAD_BEEF);
        check("md_replay_stall", stall, 6'b000000);
        check("md_count", sc, 32'd11);
        cyc(0, 0, 0, 0, 0, 32'h0000_0CCC);
        check("md_idle_rv", rv, 1'b0);

        // Simultaneous requests: MD wins; load-use waits for REPLAY and reuses the hold word.
        cyc(1, 1, 0, 0, 0, 32'hA5A5_A5A5);
        check("both_stall", stall, 6'b001111);
        cyc(0, 1, 0, 0, 0, 32'h1);
        cyc(0, 1, 1, 0, 0, 32'h2);
        check("both_md_stall", stall, 6'b001111);
        cyc(0, 1, 0, 0, 0, 32'h3);
        check("both_replay_stall", stall, 6'b000111);
        check("both_replay_inst", inst, 32'hA5A5_A5A5);
        cyc(0, 0, 0, 0, 0, 32'h4);
        check("both_bubble_rv", rv, 1'b0);
        cyc(0, 0, 0, 0, 0, 32'h5);
        check("both_replay2_inst", inst, 32'hA5A5_A5A5);
        cyc(0, 0, 0, 0, 0, 32'h6);

        // Timeout: 64 MD_WAIT cycles without md_done.
        cyc(1, 0, 0, 0, 0, 32'hCAFE_F00D);
        for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 0, 32'h200 + i);
        check("to_not_yet", to, 1'b0);
        check("to_last_stall", stall, 6'b001111);
        cyc(0, 0, 0, 0, 0, 32'h7);
        check("to_set", to, 1'b1);
        check("to_replay_inst", inst, 32'hCAFE_F00D);
        cyc(0, 1, 0, 0, 0, 32'h8);
        cyc(0, 0, 0, 0, 0, 32'h9);
        cyc(0, 0, 0, 0, 0, 32'hA);
        cyc(0, 0, 0, 0, 0, 32'hB);
        check("to_sticky", to, 1'b1);

        // Flush together with md_done on the fifth MD_WAIT cycle.
        cyc(1, 0, 0, 0, 0, 32'h1234_5678);
        for (int i = 1; i < 5; i++) cyc(0, 0, 0, 0, 0, 32'h300 + i);
        cyc(0, 0, 1, 1, 0, 32'h305);
        check("flush_stall", stall, 6'b000000);
        cyc(0, 0, 0, 0, 0, 32'h306);
        check("flush_rv", rv, 1'b0);
        check("flush_idle_stall", stall, 6'b000000);
        cyc(0, 0, 0, 0, 0, 32'h307);
        check("flush_rv2", rv, 1'b0);

        // Counter: 20 stall cycles saturate the 4-bit copy at 4'hF.
        cyc(0, 0, 0, 0, 1, 32'h0);
        cyc(1, 0, 0, 0, 0, 32'h0);
        check("sat_start", sc4, 4'h0);
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        check("sat_w32", sc, 32'd20);
        check("sat_w4", sc4, 4'hF);
        cyc(1, 0, 0, 0, 1, 32'h0);
        check("clr_stall", stall, 6'b001111);
        cyc(0, 0, 0, 0, 0, 32'h0);
        check("clr_w32", sc, 32'd0);
        check("clr_w4", sc4, 4'h0);

        // Async reset mid-cycle while in MD_WAIT.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_rst_stall", stall, 6'b000000);
        @(posedge clk); #1 rst = 1'b0;
        cyc(0, 0, 1, 0, 0, 32'h55);
        check("late_done_stall", stall, 6'b000000);
        cyc(0, 0, 0, 0, 0, 32'h56);
        check("late_done_rv", rv, 1'b0);
        check("rst_clears_to", to, 1'b0);
        cyc(0, 0, 0, 0, 0, 32'h57);

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
